rtc_timebase: RTL and testbench
===============================

# rtc_timebase

Parametrised successor to the RTC divider. The block conditions the raw master-oscillator input with a synchroniser and edge detector, then divides it in two stages: a power-of-two prescaler and a programmable terminal counter. It produces the 1 Hz strobe and the 50 % duty 0.5 Hz square wave, and adds runtime reconfiguration, periodic ppm trim, second alignment and a lost-oscillator watchdog. It sits between the oscillator pin and the RTC time-keeping counters.

## Interface
- PRESCALE_LOG2, 7: prescaler divides trig rising edges by 2^PRESCALE_LOG2.
- COUNT_WIDTH, 17: width of the terminal counter and of cfg_terminal.
- RESET_TERMINAL, 78124: terminal after reset. A period is terminal+1 ticks; the defaults give 1 Hz from 10 MHz.
- WATCHDOG_CYCLES, 1023: number of clk cycles without a trig edge before trig_lost asserts.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  raw oscillator, asynchronous to clk.
- enable  in  1  when low, the prescaler and counter freeze and no tick or one_hz is issued.
- sync_clr  in  1  clears prescaler, counter and trim count to 0 (second alignment).
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration slot free.
- cfg_terminal  in  COUNT_WIDTH  new terminal; 0 is treated as 1.
- cfg_trim_period  in  8  trim applied every N periods; 0 disables trim.
- cfg_trim_dir  in  1  0 = lengthen the trimmed period by one tick, 1 = shorten it by one tick.
- tick  out  1  one-cycle pulse per prescaler wrap.
- one_hz  out  1  one-cycle pulse at each period boundary.
- half_hz_50  out  1  toggles at each period boundary.
- trig_lost  out  1  watchdog flag.
- count  out  COUNT_WIDTH  current counter value.

## Operation
- **Input conditioning:** trig passes through two synchroniser flops. edge = s2 & ~s3. The synchroniser flops reset to 0, so if trig is high when rst releases, that counts as one edge.
- **Prescaler:** PRESCALE_LOG2-bit counter that increments on edge when enable=1. When it wraps from all-ones to 0, tick is registered high for one cycle.
- **Counter:** on a registered tick with enable=1:
  - if count == eff_terminal: count→0, one_hz pulses, half_hz_50 toggles, trim_cnt advances;
  - otherwise count+1.
- **Effective terminal (eff_terminal):** equals terminal, except in the period where trim_period≠0 and trim_cnt == trim_period−1, where it is terminal+1 (dir=0) or terminal−1 (dir=1). Shortening is ignored when terminal == 1. trim_cnt wraps to 0 after the trimmed period.
- **Configuration handshake:**
  - A transfer happens when cfg_valid & cfg_ready. The fields are captured into a pending register and cfg_ready drops.
  - Pending fields are applied at the next period boundary. On apply, trim_cnt→0 and cfg_ready rises the following cycle.
  - The period in progress always completes with the old settings.
- **sync_clr:** prescaler, count and trim_cnt→0. A tick or one_hz that would fire in the same cycle is suppressed. half_hz_50 and any pending configuration are unaffected.
- **Watchdog:** counts clk cycles since the last edge, saturating at WATCHDOG_CYCLES. trig_lost = (wd == WATCHDOG_CYCLES). An edge clears wd, and trig_lost falls the next cycle. The watchdog runs regardless of enable.
- **Priority:** rst > sync_clr > boundary/apply > count increment.

## Timing
- **Reset values:** one_hz=0, half_hz_50=0, tick=0, trig_lost=0, count=0, cfg_ready=1. terminal=RESET_TERMINAL, trim disabled, pending configuration discarded, prescaler/wd/sync flops=0.
- **Input latency:** a trig rising edge produces edge 3 clk later. trig high and low phases must each be ≥2 clk.
- **tick latency:** tick appears 1 cycle after the edge that wraps the prescaler.
- **one_hz latency:** one_hz appears 1 cycle after the terminal tick.
- **half_hz_50:** changes in the same cycle as one_hz.
- **Back-to-back configuration:** a cfg offer in the same cycle as a boundary is captured, and is applied at the following boundary, not the current one.
- **Period length:** exactly (eff_terminal+1)·2^PRESCALE_LOG2 edges.
- **Width rule:** count never exceeds terminal+1. A terminal of all-ones with dir=0 trim is not supported.

## Test plan
- PRESCALE_LOG2=2, RESET_TERMINAL=3, trig period 8 clk → tick every 32 clk, one_hz every 128 clk, half_hz_50 period 256 clk.
- Offer cfg_terminal=1 mid-period → cfg_ready low. The current period stays 4 ticks, later periods are 2 ticks, and cfg_ready is high 1 cycle after the boundary.
- cfg_trim_period=2, dir=0 → periods of 4,5,4,5 ticks. With dir=1 → 4,3,4,3.
- Stop trig with WATCHDOG_CYCLES=15 → trig_lost is high 15 cycles after the last edge. Restart trig → trig_lost clears 1 cycle after the first edge.
- Assert sync_clr in the terminal-tick cycle → no one_hz, count=0, and the next one_hz comes a full 4 ticks later.
- Assert rst mid-period with a configuration pending → all outputs at reset values, terminal=3, cfg_ready=1, and the pending values are never applied.

Source files
------------

// File: rtl/rtc_timebase.sv
// rtc_timebase
// Divides the raw master-oscillator input down to the RTC second strobe.
// trig is synchronised and edge-detected, then divided by a power-of-two
// prescaler (tick) and a programmable terminal counter (one_hz, half_hz_50).
// A single pending configuration slot allows terminal and trim changes to
// take effect cleanly on a period boundary. sync_clr realigns the second,
// and a watchdog flags a dead oscillator.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   trig            raw oscillator, asynchronous to clk
//   enable          freezes prescaler and counter when low
//   sync_clr        clears prescaler, counter and trim position
//   cfg_valid/ready configuration handshake (see below)
//   cfg_terminal    new terminal (0 is taken as 1)
//   cfg_trim_period trim every N periods, 0 disables trim
//   cfg_trim_dir    0 lengthens, 1 shortens the trimmed period by one tick
//   tick            one-cycle pulse per prescaler wrap
//   one_hz          one-cycle pulse per period boundary
//   half_hz_50      toggles at each period boundary
//   trig_lost       no trig edge seen for WATCHDOG_CYCLES clocks
//   count           current terminal-counter value
//
// Configuration handshake: a transfer occurs on any clk edge where
// cfg_valid and cfg_ready are both high; the fields are latched into the
// pending slot and cfg_ready drops. The slot is applied at the next period
// boundary and cfg_ready returns high the cycle after that boundary. The
// offerer may hold cfg_valid; nothing is captured while cfg_ready is low.
module rtc_timebase #(
    parameter int PRESCALE_LOG2   = 7,
    parameter int COUNT_WIDTH     = 17,
    parameter int RESET_TERMINAL  = 78124,
    parameter int WATCHDOG_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trig,
    input  logic                   enable,
    input  logic                   sync_clr,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [COUNT_WIDTH-1:0] cfg_terminal,
    input  logic [7:0]             cfg_trim_period,
    input  logic                   cfg_trim_dir,
    output logic                   tick,
    output logic                   one_hz,
    output logic                   half_hz_50,
    output logic                   trig_lost,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int WD_WIDTH = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0]    WD_MAX     = WD_WIDTH'(WATCHDOG_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] RESET_TERM = COUNT_WIDTH'(RESET_TERMINAL);
    localparam logic [COUNT_WIDTH-1:0] ONE        = COUNT_WIDTH'(1);

    // Input conditioning: sync1/sync2 form the synchroniser, sync3 is the
    // previous synchronised value used for rising-edge detection.
    logic sync1, sync2, sync3;
    logic trig_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= trig;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign trig_edge = sync2 & ~sync3;

    // Watchdog: saturating count of clocks since the last edge.
    logic [WD_WIDTH-1:0] wd;

    always_ff @(posedge clk) begin
        if (rst || trig_edge) begin
            wd <= '0;
        end else if (wd != WD_MAX) begin
            wd <= wd + WD_WIDTH'(1);
        end
    end

    assign trig_lost = (wd == WD_MAX);

    // Prescaler: tick is registered on the edge that wraps all-ones to 0.
    logic [PRESCALE_LOG2-1:0] presc;

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= trig_edge & enable & (&presc);
            if (trig_edge && enable) begin
                presc <= presc + PRESCALE_LOG2'(1);
            end
        end
    end

    // Active settings and the pending configuration slot.
    logic [COUNT_WIDTH-1:0] terminal, pend_terminal, eff_terminal;
    logic [7:0]             trim_period, pend_trim_period, trim_cnt;
    logic                   trim_dir, pend_trim_dir, pend_valid;
    logic                   apply_d;
    logic                   trim_now, boundary;

    // The trimmed period is the last one of each trim_period-long cycle.
    assign trim_now = (trim_period != 8'd0) && (trim_cnt == trim_period - 8'd1);

    always_comb begin
        eff_terminal = terminal;
        if (trim_now) begin
            if (!trim_dir) begin
                eff_terminal = terminal + ONE;
            end else if (terminal != ONE) begin
                // A one-tick period cannot be shortened further.
                eff_terminal = terminal - ONE;
            end
        end
    end

    assign boundary = tick & enable & (count == eff_terminal);

    always_ff @(posedge clk) begin
        if (rst) begin
            count            <= '0;
            one_hz           <= 1'b0;
            half_hz_50       <= 1'b0;
            trim_cnt         <= 8'd0;
            terminal         <= RESET_TERM;
            trim_period      <= 8'd0;
            trim_dir         <= 1'b0;
            pend_valid       <= 1'b0;
            pend_terminal    <= '0;
            pend_trim_period <= 8'd0;
            pend_trim_dir    <= 1'b0;
            cfg_ready        <= 1'b1;
            apply_d          <= 1'b0;
        end else begin
            one_hz  <= 1'b0;
            apply_d <= 1'b0;

            // cfg_ready is low whenever the slot is full or just applied,
            // so capture and apply never coincide.
            if (cfg_valid && cfg_ready) begin
                pend_valid       <= 1'b1;
                pend_terminal    <= (cfg_terminal == '0) ? ONE : cfg_terminal;
                pend_trim_period <= cfg_trim_period;
                pend_trim_dir    <= cfg_trim_dir;
                cfg_ready        <= 1'b0;
            end
            if (apply_d) begin
                cfg_ready <= 1'b1;
            end

            if (sync_clr) begin
                count    <= '0;
                trim_cnt <= 8'd0;
            end else if (boundary) begin
                count      <= '0;
                one_hz     <= 1'b1;
                half_hz_50 <= ~half_hz_50;
                if (pend_valid) begin
                    terminal    <= pend_terminal;
                    trim_period <= pend_trim_period;
                    trim_dir    <= pend_trim_dir;
                    trim_cnt    <= 8'd0;
                    pend_valid  <= 1'b0;
                    apply_d     <= 1'b1;
                end else if (trim_now || trim_period == 8'd0) begin
                    trim_cnt <= 8'd0;
                end else begin
                    trim_cnt <= trim_cnt + 8'd1;
                end
            end else if (tick && enable) begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: tb/tb_rtc_timebase.sv
// tb_rtc_timebase
// Randomised bench for rtc_timebase with a small prescaler (2^2), terminal 3
// and a 15-cycle watchdog. The driver produces trig pulses; for each pulse a
// reference model counts edges, ticks and periods and pushes the expected
// tick and one_hz events (with their clk cycle) into queues. A monitor on
// the falling clock edge compares every tick/one_hz the DUT presents with
// the queue head and checks trig_lost every cycle.
module tb_rtc_timebase;

    localparam int PL  = 2;
    localparam int CW  = 16;
    localparam int RT  = 3;
    localparam int WDC = 15;

    logic          clk = 1'b0;
    logic          rst, trig, enable, sync_clr, cfg_valid, cfg_ready, cfg_trim_dir;
    logic          tick, one_hz, half_hz_50, trig_lost;
    logic [CW-1:0] cfg_terminal, count;
    logic [7:0]    cfg_trim_period;

    rtc_timebase #(
        .PRESCALE_LOG2(PL), .COUNT_WIDTH(CW),
        .RESET_TERMINAL(RT), .WATCHDOG_CYCLES(WDC)
    ) dut (
        .clk(clk), .rst(rst), .trig(trig), .enable(enable), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_terminal(cfg_terminal),
        .cfg_trim_period(cfg_trim_period), .cfg_trim_dir(cfg_trim_dir),
        .tick(tick), .one_hz(one_hz), .half_hz_50(half_hz_50),
        .trig_lost(trig_lost), .count(count)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passes = 0;
    bit mon_en = 1'b0;

    logic [47:0] tick_exp_q[$];   // {cycle, count seen with the tick}
    logic [32:0] hz_exp_q[$];     // {cycle, half_hz_50 after toggle}

    // Reference model: edges since alignment, ticks within the period.
    int m_edges, m_ticks, m_term, m_tp, m_trim;
    bit m_dir, m_half;
    bit p_valid, p_dir;
    int p_term, p_tp;
    int ready_from;
    int last_rise, prev_rise;

    // Fields offered by the next cfg offer.
    int f_term, f_tp;
    bit f_dir;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int period_len();
        int eff;
        eff = m_term;
        if (m_tp != 0 && m_trim == m_tp - 1) begin
            if (!m_dir) eff = m_term + 1;
            else if (m_term != 1) eff = m_term - 1;
        end
        return eff + 1;
    endfunction

    function automatic bit next_is_terminal();
        return ((m_edges + 1) % (1 << PL) == 0) && (m_ticks + 1 == period_len());
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_t, exp_h;
            int r, w;
            exp_t = (tick_exp_q.size() > 0) && (tick_exp_q[0][47:16] == cyc);
            if (tick || exp_t) chk("tick", tick, exp_t);
            if (exp_t) begin
                chk("count_at_tick", count, tick_exp_q[0][15:0]);
                void'(tick_exp_q.pop_front());
            end
            exp_h = (hz_exp_q.size() > 0) && (hz_exp_q[0][32:1] == cyc);
            if (one_hz || exp_h) chk("one_hz", one_hz, exp_h);
            if (exp_h) begin
                chk("half_hz_50", half_hz_50, hz_exp_q[0][0]);
                chk("count_at_boundary", count, 0);
                void'(hz_exp_q.pop_front());
            end
            // A rise driven at cycle r clears the watchdog 3 cycles later.
            r = (cyc >= last_rise + 3) ? last_rise : prev_rise;
            w = cyc - (r + 3);
            chk("trig_lost", trig_lost, (w >= WDC));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input bit check_drain);
        if (check_drain) chk("queues_drained", tick_exp_q.size() + hz_exp_q.size(), 0);
        mon_en = 1'b0;
        rst = 1'b1; trig = 1'b0; cfg_valid = 1'b0; sync_clr = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick_exp_q.delete();
        hz_exp_q.delete();
        m_edges = 0; m_ticks = 0; m_term = RT; m_tp = 0; m_trim = 0;
        m_dir = 1'b0; m_half = 1'b0; p_valid = 1'b0;
        ready_from = cyc;
        last_rise = cyc - 3;
        prev_rise = cyc - 3;
        chk("reset_one_hz", one_hz, 0);
        chk("reset_half_hz_50", half_hz_50, 0);
        chk("reset_tick", tick, 0);
        chk("reset_trig_lost", trig_lost, 0);
        chk("reset_count", count, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        mon_en = 1'b1;
    endtask

    task automatic offer(input int c, output bit cap);
        cfg_valid       = 1'b1;
        cfg_terminal    = CW'(f_term);
        cfg_trim_period = 8'(f_tp);
        cfg_trim_dir    = f_dir;
        cap = !p_valid && (c >= ready_from);
        chk("cfg_ready_at_offer", cfg_ready, cap);
        if (cap) begin
            p_valid = 1'b1;
            p_term  = (f_term == 0) ? 1 : f_term;
            p_tp    = f_tp;
            p_dir   = f_dir;
        end
    endtask

    // One trig pulse: high 4 cycles, low 4+gap cycles. Starts and ends on a
    // falling clock edge. cfg_mode 1 offers with the rise, 2 offers in the
    // cycle where this edge's tick is visible (a possible boundary cycle).
    // clr asserts sync_clr in that same cycle.
    task automatic trig_cycle(input bit en, input bit clr, input int cfg_mode, input int gap);
        int n;
        bit cap_early, cap_late, applied;
        n = cyc;
        cap_early = 1'b0; cap_late = 1'b0; applied = 1'b0;
        enable = en;
        if (cfg_mode == 1) offer(n, cap_early);
        trig = 1'b1;
        prev_rise = last_rise;
        last_rise = n;
        if (en) begin
            m_edges++;
            if (m_edges % (1 << PL) == 0) begin
                tick_exp_q.push_back({n + 3, 16'(m_ticks)});
                if (!clr) begin
                    m_ticks++;
                    if (m_ticks == period_len()) begin
                        m_ticks = 0;
                        m_half  = ~m_half;
                        hz_exp_q.push_back({n + 4, m_half});
                        if (m_tp != 0) m_trim = (m_trim == m_tp - 1) ? 0 : m_trim + 1;
                        if (p_valid) begin
                            m_term = p_term; m_tp = p_tp; m_dir = p_dir; m_trim = 0;
                            p_valid = 1'b0;
                            ready_from = n + 5;
                            applied = 1'b1;
                        end
                    end
                end
            end
        end
        if (clr) begin
            m_edges = 0; m_ticks = 0; m_trim = 0;
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        if (cap_early) chk("cfg_ready_after_capture", cfg_ready, 0);
        repeat (2) @(negedge clk);
        if (cfg_mode == 2) offer(n + 3, cap_late);
        sync_clr = clr;
        @(negedge clk);
        cfg_valid = 1'b0; sync_clr = 1'b0; trig = 1'b0;
        if (applied || cap_late) chk("cfg_ready_low", cfg_ready, 0);
        @(negedge clk);
        if (applied) chk("cfg_ready_after_apply", cfg_ready, 1);
        repeat (3 + gap) @(negedge clk);
    endtask

    task automatic run_to_terminal();
        int guard;
        guard = 0;
        while (!next_is_terminal() && guard < 100) begin
            trig_cycle(1'b1, 1'b0, 0, 0);
            guard++;
        end
    endtask

    task automatic run_until_slot_free();
        int guard;
        guard = 0;
        while (p_valid && guard < 100) begin
            trig_cycle(1'b1, 1'b0, 0, 0);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; trig = 1'b0; enable = 1'b1; sync_clr = 1'b0; cfg_valid = 1'b0;
        cfg_terminal = '0; cfg_trim_period = 8'd0; cfg_trim_dir = 1'b0;
        f_term = 0; f_tp = 0; f_dir = 1'b0;
        do_reset(1'b0);

        // Default: three 4-tick periods at an 8-clk trig period.
        repeat (48) trig_cycle(1'b1, 1'b0, 0, 0);

        // Terminal 1 offered mid-period: current period completes as 4 ticks.
        repeat (5) trig_cycle(1'b1, 1'b0, 0, 0);
        f_term = 1; f_tp = 0; f_dir = 1'b0;
        trig_cycle(1'b1, 1'b0, 1, 0);
        repeat (40) trig_cycle(1'b1, 1'b0, 0, $urandom_range(0, 3));

        // Trim every 2nd period, lengthen, then shorten.
        run_until_slot_free();
        f_term = 3; f_tp = 2; f_dir = 1'b0;
        trig_cycle(1'b1, 1'b0, 1, 0);
        repeat (80) trig_cycle(1'b1, 1'b0, 0, $urandom_range(0, 3));
        run_until_slot_free();
        f_dir = 1'b1;
        trig_cycle(1'b1, 1'b0, 1, 0);
        repeat (80) trig_cycle(1'b1, 1'b0, 0, $urandom_range(0, 3));

        // Offer in the boundary cycle: applied one boundary later.
        run_until_slot_free();
        run_to_terminal();
        f_term = 2; f_tp = 0; f_dir = 1'b0;
        trig_cycle(1'b1, 1'b0, 2, 0);
        repeat (40) trig_cycle(1'b1, 1'b0, 0, 0);

        // sync_clr in the terminal-tick cycle.
        run_to_terminal();
        trig_cycle(1'b1, 1'b1, 0, 0);
        repeat (32) trig_cycle(1'b1, 1'b0, 0, 0);

        // Enable low for a few edges.
        repeat (6) trig_cycle(1'b0, 1'b0, 0, $urandom_range(0, 3));
        repeat (20) trig_cycle(1'b1, 1'b0, 0, 0);

        // Random mix of everything.
        for (int i = 0; i < 300; i++) begin
            f_term = $urandom_range(0, 5);
            f_tp   = $urandom_range(0, 3);
            f_dir  = 1'($urandom_range(0, 1));
            trig_cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 5) > 2) ? 0 : $urandom_range(1, 2),
                       $urandom_range(0, 3));
        end

        // Oscillator stops, then restarts.
        repeat (25) @(negedge clk);
        repeat (8) trig_cycle(1'b1, 1'b0, 0, 0);

        // Reset with a configuration pending: it must never take effect.
        run_until_slot_free();
        run_to_terminal();
        trig_cycle(1'b1, 1'b0, 0, 0);
        f_term = 1; f_tp = 1; f_dir = 1'b0;
        trig_cycle(1'b1, 1'b0, 1, 0);
        trig_cycle(1'b1, 1'b0, 0, 0);
        do_reset(1'b1);
        repeat (48) trig_cycle(1'b1, 1'b0, 0, 0);

        repeat (10) @(negedge clk);
        chk("final_queues_empty", tick_exp_q.size() + hz_exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
